// File: rtl/display_ram_engine_if.sv
// Bus bundle for the display RAM: CPU port A, video scan port B and the
// fill/scroll engine command/status lines.
interface display_ram_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 10
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              b_en;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rdata;
  logic              cmd_fill;
  logic              cmd_scroll;
  logic [DATA_W-1:0] fill_data;
  logic              busy;
  logic              done;

  modport master (
    output a_req, a_we, a_addr, a_wdata, b_en, b_addr, cmd_fill, cmd_scroll, fill_data,
    input  a_ready, a_rdata, a_rvalid, b_rdata, busy, done
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata, b_en, b_addr, cmd_fill, cmd_scroll, fill_data,
    output a_ready, a_rdata, a_rvalid, b_rdata, busy, done
  );
endinterface

// File: rtl/display_ram_engine.sv
// Dual-port character display buffer with a clear-screen fill engine and a
// one-row scroll-up engine sharing the single write port with CPU port A.
module display_ram_engine #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       DEPTH      = 1024,
  parameter int unsigned       ROW_LEN    = 64,
  parameter logic [DATA_W-1:0] FILL_VALUE = DATA_W'(8'h20),
  parameter int unsigned       READ_LAT_B = 2
) (
  input logic                 clk,
  input logic                 reset,
  display_ram_engine_if.slave bus
);

  // ptr is one bit wider than the address so DEPTH == 2**ADDR_W never wraps
  localparam int unsigned      PTR_W        = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P      = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_P       = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ROW_P        = PTR_W'(ROW_LEN);
  localparam logic [PTR_W-1:0] SHIFT_LAST_P = PTR_W'(DEPTH - ROW_LEN - 1);
  localparam bit               B_BYPASS     = (READ_LAT_B == 1);

  typedef enum logic [2:0] {IDLE, FILL, SCR_RD, SCR_WR, SCR_CLR} state_e;

  state_e            state_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [DATA_W-1:0] fill_q;
  logic [DATA_W-1:0] scr_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic              a_rvalid_q;
  logic [DATA_W-1:0] b_s1_q;
  logic [DATA_W-1:0] b_s2_q;
  logic              b_v1_q;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_VALUE};

  logic              a_fire_c;
  logic              a_in_range_c;
  logic              b_in_range_c;
  logic              eng_we_c;
  logic [ADDR_W-1:0] eng_addr_c;
  logic [DATA_W-1:0] eng_wdata_c;

  assign bus.a_ready  = ~busy_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rdata  = B_BYPASS ? b_s1_q : b_s2_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  assign a_fire_c     = bus.a_req & ~busy_q;
  assign a_in_range_c = {1'b0, bus.a_addr} < DEPTH_P;
  assign b_in_range_c = {1'b0, bus.b_addr} < DEPTH_P;

  // Engine write request; port A can never collide since it is stalled while busy
  always_comb begin
    eng_we_c    = 1'b0;
    eng_addr_c  = ADDR_W'(ptr_q);
    eng_wdata_c = fill_q;
    case (state_q)
      FILL, SCR_CLR: eng_we_c = 1'b1;
      SCR_WR: begin
        eng_we_c    = 1'b1;
        eng_wdata_c = scr_q;
      end
      default: eng_we_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (eng_we_c) begin
      mem[eng_addr_c] <= eng_wdata_c;
    end else if (a_fire_c && bus.a_we && a_in_range_c) begin
      mem[bus.a_addr] <= bus.a_wdata;
    end
  end

  // Read ports sample the array before this edge's write lands
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q  <= '0;
      a_rvalid_q <= 1'b0;
      b_s1_q     <= '0;
      b_s2_q     <= '0;
      b_v1_q     <= 1'b0;
    end else begin
      a_rvalid_q <= a_fire_c & ~bus.a_we;
      if (a_fire_c && !bus.a_we) begin
        a_rdata_q <= a_in_range_c ? mem[bus.a_addr] : '0;
      end
      b_v1_q <= bus.b_en;
      if (bus.b_en) begin
        b_s1_q <= b_in_range_c ? mem[bus.b_addr] : '0;
      end
      if (b_v1_q) begin
        b_s2_q <= b_s1_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      fill_q  <= '0;
      scr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_fill) begin
            state_q <= FILL;
            ptr_q   <= '0;
            fill_q  <= bus.fill_data;
            busy_q  <= 1'b1;
          end else if (bus.cmd_scroll) begin
            state_q <= SCR_RD;
            ptr_q   <= '0;
            fill_q  <= bus.fill_data;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_P) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        SCR_RD: begin
          scr_q   <= mem[ADDR_W'(ptr_q + ROW_P)];
          state_q <= SCR_WR;
        end
        SCR_WR: begin
          ptr_q   <= ptr_q + 1'b1;
          state_q <= (ptr_q < SHIFT_LAST_P) ? SCR_RD : SCR_CLR;
        end
        SCR_CLR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == LAST_P) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_ram_engine.sv
// Directed bench for display_ram_engine: a reference cell array feeds read
// scoreboards for ports A and B, plus engine busy/done timing checks.
module tb_display_ram_engine;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned ROW_LEN = 64;
  localparam int unsigned B_LAT   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  display_ram_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  display_ram_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ROW_LEN(ROW_LEN),
    .FILL_VALUE(8'h20), .READ_LAT_B(B_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [1:0] b_hist = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard pop side: compare every DUT read result against the queued expectation
  always @(posedge clk) begin
    b_hist = {b_hist[0], bus.b_en};
    #1;
    if (bus.a_rvalid === 1'b1) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", 32'(bus.a_rvalid), 0);
      else                chk("a_rdata", 32'(bus.a_rdata), 32'(qa.pop_front()));
    end
    if (b_hist[B_LAT-1]) begin
      if (qb.size() == 0) chk("b_queue_underrun", 32'(qb.size()), 1);
      else                chk("b_rdata", 32'(bus.b_rdata), 32'(qb.pop_front()));
    end
  end

  task automatic b_sweep();
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.b_en   = 1'b1;
      bus.b_addr = ADDR_W'(i);
      qb.push_back(model[i]);
      @(posedge clk); #1;
    end
    bus.b_en = 1'b0;
    repeat (B_LAT + 1) @(posedge clk);
    #1;
    chk("b_hold", 32'(bus.b_rdata), 32'(model[DEPTH-1]));
  endtask

  task automatic issue(input logic f, input logic s, input logic [7:0] fd);
    bus.cmd_fill   = f;
    bus.cmd_scroll = s;
    bus.fill_data  = fd;
    @(posedge clk); #1;
    bus.cmd_fill   = 1'b0;
    bus.cmd_scroll = 1'b0;
    bus.b_en       = 1'b0;
  endtask

  task automatic engine_wait(input string tag, input int exp_cyc);
    int cyc   = 0;
    int dones = 0;
    int rdy   = 0;
    while (bus.busy === 1'b1 && cyc < 5000) begin
      rdy   += int'(bus.a_ready);
      dones += int'(bus.done);
      cyc++;
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_ready_while_busy"}, 32'(rdy), 0);
    chk({tag, "_done_early"}, 32'(dones), 0);
    chk({tag, "_done_pulse"}, 32'(bus.done), 1);
    chk({tag, "_ready_after"}, 32'(bus.a_ready), 1);
    @(posedge clk); #1;
    chk({tag, "_done_clear"}, 32'(bus.done), 0);
    chk({tag, "_busy_stays_low"}, 32'(bus.busy), 0);
  endtask

  initial begin
    int quiet;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_en = 1'b0; bus.b_addr = '0;
    bus.cmd_fill = 1'b0; bus.cmd_scroll = 1'b0; bus.fill_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h20;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_a_ready", 32'(bus.a_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
    chk("rst_a_rdata", 32'(bus.a_rdata), 0);
    chk("rst_b_rdata", 32'(bus.b_rdata), 0);

    // Power-up contents
    b_sweep();

    // Port A write with a same-cycle port B read of the same cell, then read back
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = '0; bus.a_wdata = 8'h41;
    bus.b_en = 1'b1; bus.b_addr = '0;
    qb.push_back(model[0]);
    chk("wr_a_ready", 32'(bus.a_ready), 1);
    @(posedge clk); #1;
    model[0] = 8'h41;
    bus.a_we = 1'b0;
    qb.push_back(model[0]);
    qa.push_back(model[0]);
    @(posedge clk); #1;
    bus.a_req = 1'b0; bus.b_en = 1'b0;
    chk("rd_a_rvalid_pulse", 32'(bus.a_rvalid), 1);
    @(posedge clk); #1;
    chk("rd_a_rvalid_low", 32'(bus.a_rvalid), 0);
    chk("rd_a_rdata_hold", 32'(bus.a_rdata), 8'h41);
    repeat (2) @(posedge clk);
    #1;

    // Reset 100 cycles into a fill of 0x00
    issue(1'b1, 1'b0, 8'h00);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_a_ready", 32'(bus.a_ready), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    quiet = 0;
    repeat (5) begin
      @(posedge clk); #1;
      quiet += int'(bus.done) + int'(bus.busy);
    end
    chk("abort_no_done", 32'(quiet), 0);
    for (int i = 0; i < 100; i++) model[i] = 8'h00;
    b_sweep();

    // Fill 0x2A; port B reads the last cell while busy, port A read held across busy
    bus.b_en = 1'b1; bus.b_addr = ADDR_W'(DEPTH - 1);
    qb.push_back(model[DEPTH-1]);
    issue(1'b1, 1'b0, 8'h2A);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = ADDR_W'(5);
    qa.push_back(8'h2A);
    engine_wait("fill", int'(DEPTH));
    chk("fill_held_read_accepted", 32'(bus.a_rvalid), 1);
    bus.a_req = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h2A;
    b_sweep();

    // Row-index pattern then a one-row scroll with 0x20 blanking
    for (int i = 0; i < int'(DEPTH); i++) begin
      bus.a_req = 1'b1; bus.a_we = 1'b1;
      bus.a_addr = ADDR_W'(i); bus.a_wdata = 8'(i / int'(ROW_LEN));
      model[i] = 8'(i / int'(ROW_LEN));
      @(posedge clk); #1;
    end
    bus.a_req = 1'b0; bus.a_we = 1'b0;
    issue(1'b0, 1'b1, 8'h20);
    engine_wait("scroll", 2 * int'(DEPTH - ROW_LEN) + int'(ROW_LEN));
    for (int i = 0; i < int'(DEPTH); i++)
      model[i] = (i < int'(DEPTH - ROW_LEN)) ? model[i + int'(ROW_LEN)] : 8'h20;
    b_sweep();

    // Fill beats scroll in the same cycle; a later scroll while busy is ignored
    issue(1'b1, 1'b1, 8'h55);
    bus.cmd_scroll = 1'b1; bus.fill_data = 8'h77;
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_scroll = 1'b0;
    chk("both_busy", 32'(bus.busy), 1);
    engine_wait("both", int'(DEPTH) - 3);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h55;
    b_sweep();

    repeat (4) @(posedge clk);
    #1;
    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_ram_engine.md
Name: display_ram_engine

Overview:
- Parametrised dual-port character display buffer: CPU port A (read/write with ready handshake) and video scan port B (read-only, configurable latency).
- Adds a hardware fill engine (clear screen) and a one-row scroll-up engine; neither exists in the fixed 1Kx8 display RAM.
- Sits between the Z80 bus decode and the video character generator; DEPTH/ROW_LEN cover the 64x16 and 80x24 screen modes.

Parameters:
- DATA_W, 8, character width in bits.
- ADDR_W, 10, address width; requires DEPTH <= 2**ADDR_W.
- DEPTH, 1024, number of character cells.
- ROW_LEN, 64, cells per text row; DEPTH must be a multiple of ROW_LEN, and ROW_LEN < DEPTH.
- FILL_VALUE, 8'h20, configuration-time contents of every cell; default blank for the fill engine.
- READ_LAT_B, 2, port B read latency in cycles: 1 = bypass, 2 = output register.

Ports:
- clk  in  1  single clock for both ports and the engines.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  port A access request.
- a_we  in  1  1 = write, 0 = read; sampled with a_req.
- a_addr  in  ADDR_W  port A cell address.
- a_wdata  in  DATA_W  port A write data.
- a_ready  out  1  port A accepts the access this cycle.
- a_rdata  out  DATA_W  port A read data.
- a_rvalid  out  1  a_rdata valid (1-cycle pulse).
- b_en  in  1  port B read enable.
- b_addr  in  ADDR_W  port B cell address.
- b_rdata  out  DATA_W  port B read data.
- cmd_fill  in  1  pulse: start the fill engine.
- cmd_scroll  in  1  pulse: start a one-row scroll-up.
- fill_data  in  DATA_W  fill character; sampled on command acceptance.
- busy  out  1  an engine is running.
- done  out  1  1-cycle pulse after an engine completes.

Behaviour:
- Reset (async assert, sync release):
  - a_rdata, a_rvalid, b_rdata, busy, done = 0; a_ready = 1; engine state = IDLE.
  - RAM contents are not cleared by reset; initial contents are FILL_VALUE.
- a_ready = ~busy (combinational).
- Port A transfer occurs when a_req & a_ready on a rising clk edge.
  - Write: the cell is updated at that edge.
  - Read: a_rdata holds the data and a_rvalid = 1 on the following cycle.
  - a_rdata holds its value until the next read.
- Port B: b_rdata holds mem[b_addr] READ_LAT_B cycles after b_en is sampled high, and holds when b_en = 0.
- Port B is never blocked by the engines.
- Port B read of a cell written by A or an engine in the same cycle returns the old data (read-before-write).
- Address >= DEPTH:
  - Port A writes are dropped; reads return 0 with a_rvalid still pulsed.
  - Port B returns 0.
- Commands are accepted only in IDLE.
  - Both commands in the same cycle: fill wins and scroll is discarded.
  - Commands while busy are ignored.
  - A port A access in the same cycle as an accepted command completes first; busy rises the next cycle.
- States: IDLE, FILL, SCR_RD, SCR_WR, SCR_CLR.
  - IDLE -> FILL on cmd_fill: ptr = 0, fill_reg = fill_data.
  - FILL: write fill_reg to ptr, one cell per cycle, ptr += 1. After ptr = DEPTH-1, go to IDLE with a done pulse. Takes DEPTH cycles.
  - IDLE -> SCR_RD on cmd_scroll: ptr = 0, fill_reg = fill_data.
  - SCR_RD: read mem[ptr+ROW_LEN], then go to SCR_WR.
  - SCR_WR: write the read data to mem[ptr], ptr += 1. Go back to SCR_RD while ptr < DEPTH-ROW_LEN-1; otherwise go to SCR_CLR.
  - SCR_CLR: write fill_reg to ptr for ptr = DEPTH-ROW_LEN .. DEPTH-1, then go to IDLE with a done pulse.
  - Scroll takes 2*(DEPTH-ROW_LEN)+ROW_LEN cycles; 1984 at the defaults.
- busy is high in every non-IDLE state.
- done goes high on the cycle busy falls, for exactly 1 cycle.
- Reset mid-engine: abort immediately, busy = 0, no done pulse; RAM is left partially updated.
- ptr width is ADDR_W+1, so there is no wrap at DEPTH = 2**ADDR_W.

Test Plan:
- Reset, then port A write 0x41 to 0x000 and read 0x000 -> a_ready = 1; a_rvalid pulses 1 cycle after the read with a_rdata = 0x41. Port B read of 0x000 gives 0x41 after READ_LAT_B cycles.
- Power-up with no writes; port B reads 0x000..0x3FF -> all read 0x20.
- cmd_fill with fill_data = 0x2A -> busy high for 1024 cycles, a_ready = 0 throughout, done for 1 cycle. Every cell then reads 0x2A, and port A requests held during busy are accepted the cycle busy falls.
- Write the row index (0..15) into every cell of each row, then cmd_scroll with fill_data = 0x20 -> busy for 1984 cycles. Row r then holds r+1 for r = 0..14, and row 15 holds 0x20.
- cmd_fill and cmd_scroll in the same cycle, then cmd_scroll again while busy -> only the fill runs (1024 cycles, one done pulse), and the contents equal the fill pattern.
- Assert reset 100 cycles into a fill with fill_data = 0x00 over all-0x20 contents -> busy = 0 immediately and no done pulse. Cells 0..~99 read 0x00, and cells 0x100..0x3FF still read 0x20.
